kc_load_arbiter: RTL and testbench

- Shares the single byte-wide main-memory port between the Z80 CPU and the HPS ioctl download stream (TAP and M025 ROM images).
- Decodes TAP (KC tape) files on the fly: strips the 16-byte file header and the per-block sequence bytes, extracts the KCC load and end addresses, and writes the payload to memory.
- Throttles hps_io with ioctl_wait while a loader write is pending.
- Sits inside kc854, between hps_io's ioctl outputs, the CPU bus interface and the RAM.

---
 rtl/kc_load_arbiter.sv | 244 ++++++++++++++++++++++++
 tb/tb_kc_load_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kc_load_arbiter.sv
// KC85/4 memory-port arbiter: shares the RAM port between the Z80 and the hps_io ioctl
// download (TAP tape images and the M025 ROM). Optional autostart outputs: KC_LOAD_AUTOSTART_EN.
module kc_load_arbiter #(
  parameter logic [7:0]  TAP_INDEX  = 8'd1,
  parameter logic [7:0]  ROM_INDEX  = 8'd2,
  parameter logic [15:0] ROM_BASE   = 16'h4000,
  parameter int          ROM_SIZE   = 8192,
  parameter int          STARVE_MAX = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  output logic        ioctl_wait,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        load_busy,
`ifdef KC_LOAD_AUTOSTART_EN
  output logic        start_valid,
  output logic [15:0] start_addr,
`endif
  output logic        load_err
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, CPU_RD, CPU_WR_DONE, LD_WR} state_t;

  state_t        state, state_nx;
  logic [SW-1:0] starve_cnt;
  logic          cpu_grant, ld_grant, starved;

  logic          dl_q, busy, err;
  logic          buf_full;
  logic [15:0]   buf_addr;
  logic [7:0]    buf_data;
  logic [24:0]   file_cnt, pay_cnt;
  logic [7:0]    blk_pos;
  logic [15:0]   load_addr, end_addr;

  logic          dl_rise, tap_sel, rom_sel, accept;
  logic          tap_hdr_done, tap_payload, tap_write, rom_in_range;
  logic [15:0]   tap_waddr, want_addr;
  logic          want_write, capture, overflow;

  // ---------------------------------------------------------------------------
  // Download decode
  // ---------------------------------------------------------------------------
  assign dl_rise = ioctl_download & ~dl_q;
  assign tap_sel = (ioctl_index == TAP_INDEX);
  assign rom_sel = (ioctl_index == ROM_INDEX);
  // The cycle that starts a download only clears state; hps_io never strobes a byte there.
  assign accept  = ioctl_wr & (tap_sel | rom_sel) & ~dl_rise;

  assign tap_hdr_done = (file_cnt >= 25'd16);
  assign tap_payload  = tap_hdr_done & (blk_pos != 8'd0);
  assign tap_waddr    = load_addr + pay_cnt[15:0] - 16'd128;
  assign tap_write    = tap_payload & (pay_cnt >= 25'd128) & (tap_waddr < end_addr);
  assign rom_in_range = (ioctl_addr < 25'(ROM_SIZE));

  assign want_write = accept & (tap_sel ? tap_write : rom_in_range);
  assign want_addr  = tap_sel ? tap_waddr : ROM_BASE + ioctl_addr[15:0];
  assign capture    = want_write & ~buf_full;
  assign overflow   = accept & buf_full;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_q      <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      buf_full  <= 1'b0;
      file_cnt  <= '0;
      blk_pos   <= '0;
      pay_cnt   <= '0;
      load_addr <= '0;
      end_addr  <= '0;
    end else begin
      dl_q <= ioctl_download;
      if (dl_rise) begin
        busy      <= 1'b1;
        err       <= 1'b0;
        file_cnt  <= '0;
        blk_pos   <= '0;
        pay_cnt   <= '0;
        load_addr <= '0;
        end_addr  <= '0;
      end else begin
        if (!ioctl_download && !buf_full) busy <= 1'b0;
        if (accept) begin
          file_cnt <= file_cnt + 25'd1;
          if ((ioctl_addr != file_cnt) || overflow || (!tap_sel && !rom_in_range)) err <= 1'b1;
          // Dropped bytes still advance the position so later bytes decode in place.
          if (tap_sel && tap_hdr_done) begin
            blk_pos <= (blk_pos == 8'd128) ? 8'd0 : blk_pos + 8'd1;
            if (blk_pos != 8'd0) begin
              pay_cnt <= pay_cnt + 25'd1;
              case (pay_cnt)
                25'd17:  load_addr[7:0]  <= ioctl_data;
                25'd18:  load_addr[15:8] <= ioctl_data;
                25'd19:  end_addr[7:0]   <= ioctl_data;
                25'd20:  end_addr[15:8]  <= ioctl_data;
                default: ;
              endcase
            end
          end
        end
      end
      if (ld_grant) buf_full <= 1'b0;
      if (capture)  buf_full <= 1'b1;
    end
  end

  // NOTE: buffer payload needs no reset; buf_full alone says whether it is meaningful.
  always_ff @(posedge clk_sys) begin
    if (capture) begin
      buf_addr <= want_addr;
      buf_data <= ioctl_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory port arbiter
  // ---------------------------------------------------------------------------
  assign starved = buf_full & (starve_cnt == SW'(STARVE_MAX));

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state <= state_nx;
      if (ld_grant)
        starve_cnt <= '0;
      else if (cpu_grant && buf_full && (starve_cnt != SW'(STARVE_MAX)))
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_nx  = state;
    cpu_grant = 1'b0;
    ld_grant  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_ack   = 1'b0;
    cpu_rdata = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (cpu_req && !starved) begin
            cpu_grant = 1'b1;
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_we ? cpu_wdata : 8'h00;
            state_nx  = cpu_we ? CPU_WR_DONE : CPU_RD;
          end else if (buf_full) begin
            ld_grant  = 1'b1;
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = buf_addr;
            mem_wdata = buf_data;
            state_nx  = LD_WR;
          end
        end
        CPU_RD: begin
          cpu_ack   = 1'b1;
          cpu_rdata = mem_rdata;
          state_nx  = IDLE;
        end
        CPU_WR_DONE: begin
          cpu_ack  = 1'b1;
          state_nx = IDLE;
        end
        LD_WR:   state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Reset forces the stall low in the very cycle it is sampled, abandoning any download.
  assign ioctl_wait = buf_full & ~reset;
  assign load_busy  = busy & ~reset;
  assign load_err   = err & ~reset;

`ifdef KC_LOAD_AUTOSTART_EN
  logic [7:0]  arg_cnt;
  logic [15:0] start_lat, start_q;
  logic        tap_seen, start_pulse;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      arg_cnt     <= '0;
      start_lat   <= '0;
      start_q     <= '0;
      tap_seen    <= 1'b0;
      start_pulse <= 1'b0;
    end else begin
      start_pulse <= 1'b0;
      if (dl_rise) begin
        arg_cnt   <= '0;
        start_lat <= '0;
        start_q   <= '0;
        tap_seen  <= 1'b0;
      end else begin
        if (accept && tap_sel) tap_seen <= 1'b1;
        if (accept && tap_sel && tap_payload) begin
          case (pay_cnt)
            25'd16:  arg_cnt          <= ioctl_data;
            25'd21:  start_lat[7:0]   <= ioctl_data;
            25'd22:  start_lat[15:8]  <= ioctl_data;
            default: ;
          endcase
        end
        // Same condition that drops load_busy: the TAP is fully written.
        if (busy && !ioctl_download && !buf_full && tap_seen && (arg_cnt >= 8'd3)) begin
          start_pulse <= 1'b1;
          start_q     <= start_lat;
        end
      end
    end
  end

  assign start_valid = start_pulse & ~reset;
  assign start_addr  = reset ? 16'h0000 : start_q;
`endif

endmodule

// File: tb/tb_kc_load_arbiter.sv
// Self-checking bench for kc_load_arbiter: directed steps with randomized data and CPU
// traffic, checked against a file-level TAP/ROM reference model.
module tb_kc_load_arbiter;

  localparam logic [7:0]  TAP = 8'd1;
  localparam logic [7:0]  ROM = 8'd2;
  localparam logic [15:0] ROM_BASE = 16'h4000;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download, ioctl_wr, ioctl_wait;
  logic [7:0]  ioctl_index, ioctl_data;
  logic [24:0] ioctl_addr;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        load_busy, load_err;
`ifdef KC_LOAD_AUTOSTART_EN
  logic        start_valid;
  logic [15:0] start_addr;
`endif

  kc_load_arbiter dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wait(ioctl_wait),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .load_busy(load_busy),
`ifdef KC_LOAD_AUTOSTART_EN
    .start_valid(start_valid), .start_addr(start_addr),
`endif
    .load_err(load_err)
  );

  always #5 clk_sys = ~clk_sys;

  // RAM environment: unwritten bytes read back as a fixed address pattern.
  logic [7:0] ram [0:65535];
  logic       written [0:65535];
  always @(posedge clk_sys) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]     <= mem_wdata;
        written[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= (written[mem_addr] === 1'b1) ? ram[mem_addr] : (mem_addr[7:0] ^ 8'h5A);
      end
    end
  end

  // Bus monitor, sampled on the falling edge.
  logic [23:0] wr_q[$];
  int          starve_q[$];
  int          run_q[$];
  int          grants_w = 0, run = 0, mem_en_cnt = 0, ack_cnt = 0, sv_cnt = 0;
  always @(negedge clk_sys) begin
    if (mem_en && mem_we) begin
      wr_q.push_back({mem_addr, mem_wdata});
      starve_q.push_back(grants_w);
      grants_w = 0;
    end
    if (mem_en && !mem_we && ioctl_wait) grants_w++;
    if (mem_en) mem_en_cnt++;
    if (cpu_ack) ack_cnt++;
    if (ioctl_wait) run++;
    else if (run != 0) begin
      run_q.push_back(run);
      run = 0;
    end
`ifdef KC_LOAD_AUTOSTART_EN
    if (start_valid) sv_cnt++;
`endif
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  file_q[$];
  logic [23:0] exp_q[$];

  task automatic build_tap(input logic [15:0] ld, input logic [15:0] en, input logic [15:0] st,
                           input logic [7:0] args, input int ndata);
    logic [7:0] b;
    file_q.delete();
    for (int i = 0; i < 16; i++) file_q.push_back(8'($urandom));
    for (int k = 0; k < 128 + ndata; k++) begin
      if (k % 128 == 0) file_q.push_back(8'(k / 128 + 1));
      case (k)
        16: b = args;
        17: b = ld[7:0];
        18: b = ld[15:8];
        19: b = en[7:0];
        20: b = en[15:8];
        21: b = st[7:0];
        22: b = st[15:8];
        default: b = 8'($urandom);
      endcase
      file_q.push_back(b);
    end
  endtask

  // Writes a tape file produces, derived from the file offset alone.
  function automatic void tap_model();
    logic [15:0] ld, en, a;
    int p, k;
    ld = '0; en = '0;
    exp_q.delete();
    for (int i = 16; i < file_q.size(); i++) begin
      p = i - 16;
      if (p % 129 != 0) begin
        k = p - (p / 129) - 1;
        if (k == 17) ld[7:0]  = file_q[i];
        if (k == 18) ld[15:8] = file_q[i];
        if (k == 19) en[7:0]  = file_q[i];
        if (k == 20) en[15:8] = file_q[i];
        if (k >= 128) begin
          a = 16'(int'(ld) + k - 128);
          if (a < en) exp_q.push_back({a, file_q[i]});
        end
      end
    end
  endfunction

  // ---------------- drivers (all return at posedge+1) ----------------
  task automatic hps_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d,
                          input bit honour = 1'b1);
    int t = 0;
    if (honour) begin
      while (ioctl_wait && t < 400) begin
        @(posedge clk_sys); #1;
        t++;
      end
      check("wait_bound", 32'(t >= 400), 32'd0);
    end
    ioctl_index = idx; ioctl_addr = a; ioctl_data = d; ioctl_wr = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic dl_start(input logic [7:0] idx);
    ioctl_index = idx; ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
  endtask

  task automatic dl_end();
    int t = 0;
    ioctl_download = 1'b0;
    while (load_busy && t < 100) begin
      @(posedge clk_sys); #1;
      t++;
    end
    check("busy_fall_bound", 32'(t >= 100), 32'd0);
  endtask

  task automatic send_file(input logic [7:0] idx);
    for (int i = 0; i < file_q.size(); i++) hps_byte(idx, 25'(i), file_q[i]);
  endtask

  task automatic cpu_access(input logic we, input logic [15:0] a, input logic [7:0] wd,
                            output logic [7:0] rd, output int lat);
    cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
    lat = 0; rd = 'x;
    while (lat < 200) begin
      @(negedge clk_sys);
      if (cpu_ack) begin
        rd = cpu_rdata;
        break;
      end
      lat++;
    end
    check("cpu_ack_bound", 32'(lat >= 200), 32'd0);
    @(posedge clk_sys); #1;
    cpu_req = 1'b0;
  endtask

  task automatic cpu_burst(input int n);
    logic [15:0] a;
    logic [7:0]  rd;
    int          lat;
    for (int i = 0; i < n; i++) begin
      a = 16'hF000 | 16'($urandom_range(0, 255));
      repeat ($urandom_range(0, 4)) begin @(posedge clk_sys); #1; end
      cpu_access(1'b0, a, 8'h00, rd, lat);
      check("cpu_rd_data", rd, a[7:0] ^ 8'h5A);
    end
  endtask

  task automatic check_writes(input string tag, input int base);
    check({tag, "_cnt"}, wr_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < wr_q.size(); i++)
      check(tag, wr_q[base + i], exp_q[i]);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int          base, en0, ack0, rbase, sbase, svb, lat, t;
    logic [7:0]  rd;
    logic [15:0] ld;

    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_index = '0;
    ioctl_addr = '0; ioctl_data = '0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hF000; cpu_wdata = '0;

    // Reset: outputs quiet even with a CPU request pending.
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("rst_mem_en", mem_en, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_wait", ioctl_wait, 0);
    check("rst_busy", load_busy, 0);
    check("rst_err", load_err, 0);
    check("rst_mem_addr", mem_addr, 0);
    @(posedge clk_sys); #1;
    reset = 1'b0; cpu_req = 1'b0;
    @(posedge clk_sys); #1;

    // CPU write then read-back; uncontested latency is grant + 1 cycle.
    cpu_access(1'b1, 16'hF100, 8'h3C, rd, lat);
    check("cpu_wr_lat", lat, 1);
    cpu_access(1'b0, 16'hF100, 8'h00, rd, lat);
    check("cpu_rd_lat", lat, 1);
    check("cpu_rd_back", rd, 8'h3C);

    // TAP: load 0x0300, end 0x0302, data AA BB CC -> only two writes, no CPU traffic.
    build_tap(16'h0300, 16'h0302, 16'h0310, 8'd3, 3);
    file_q[file_q.size() - 3] = 8'hAA;
    file_q[file_q.size() - 2] = 8'hBB;
    file_q[file_q.size() - 1] = 8'hCC;
    base = wr_q.size(); en0 = mem_en_cnt; ack0 = ack_cnt; svb = sv_cnt;
    dl_start(TAP);
    check("tap1_busy", load_busy, 1);
    send_file(TAP);
    dl_end();
    check("tap1_cnt", wr_q.size() - base, 2);
    check("tap1_w0", wr_q[base], {16'h0300, 8'hAA});
    check("tap1_w1", wr_q[base + 1], {16'h0301, 8'hBB});
    check("tap1_no_cpu", mem_en_cnt - en0, 2);
    check("tap1_no_ack", ack_cnt - ack0, 0);
    check("tap1_err", load_err, 0);
    repeat (3) begin @(posedge clk_sys); #1; end
`ifdef KC_LOAD_AUTOSTART_EN
    check("auto_pulses", sv_cnt - svb, 1);
    check("auto_addr", start_addr, 16'h0310);
`endif

    // ROM 11 22 33 44: short stalls, busy falls only after the last write.
    file_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back({ROM_BASE + 16'(i), file_q[i]});
    base = wr_q.size(); rbase = run_q.size();
    dl_start(ROM);
    send_file(ROM);
    dl_end();
    check_writes("rom4", base);
    check("rom4_runs", run_q.size() - rbase, 4);
    for (int i = rbase; i < run_q.size(); i++)
      check("rom4_wait_len", 32'(run_q[i] >= 1 && run_q[i] <= 2), 32'd1);
    check("rom4_err", load_err, 0);

    // Starvation: CPU hogs the port; each loader byte waits exactly 8 grants.
    file_q.delete();
    for (int i = 0; i < 4; i++) file_q.push_back(8'($urandom));
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back({ROM_BASE + 16'(i), file_q[i]});
    cpu_we = 1'b0; cpu_addr = 16'hF010; cpu_req = 1'b1;
    base = wr_q.size(); sbase = starve_q.size();
    dl_start(ROM);
    send_file(ROM);
    t = 0;
    while (wr_q.size() - base < 4 && t < 200) begin @(posedge clk_sys); #1; t++; end
    check("starve_flush_bound", 32'(t >= 200), 32'd0);
    ack0 = ack_cnt;
    repeat (10) begin @(posedge clk_sys); #1; end
    check("starve_acks_resume", 32'(ack_cnt > ack0), 32'd1);
    cpu_req = 1'b0;
    repeat (2) begin @(posedge clk_sys); #1; end
    dl_end();
    check_writes("starve_rom", base);
    for (int i = sbase; i < starve_q.size(); i++) check("starve_grants", starve_q[i], 8);

    // Offset mismatch: byte still written at its own address.
    base = wr_q.size();
    dl_start(ROM);
    hps_byte(ROM, 25'd0, 8'h5E);
    hps_byte(ROM, 25'd1, 8'h6F);
    check("seq_err_clear", load_err, 0);
    hps_byte(ROM, 25'd5, 8'h70);
    dl_end();
    check("seq_err", load_err, 1);
    exp_q = '{{16'h4000, 8'h5E}, {16'h4001, 8'h6F}, {16'h4005, 8'h70}};
    check_writes("seq", base);

    // ROM byte beyond the image size is dropped.
    base = wr_q.size();
    dl_start(ROM);
    check("rom_range_err_clear", load_err, 0);
    hps_byte(ROM, 25'd0, 8'h81);
    hps_byte(ROM, 25'd8192, 8'h82);
    dl_end();
    check("rom_range_err", load_err, 1);
    exp_q = '{{16'h4000, 8'h81}};
    check_writes("rom_range", base);

    // Strobe ignoring ioctl_wait: second byte dropped, next download clears the error.
    base = wr_q.size();
    dl_start(ROM);
    hps_byte(ROM, 25'd0, 8'h91);
    check("ovf_wait", ioctl_wait, 1);
    hps_byte(ROM, 25'd1, 8'h92, 1'b0);
    dl_end();
    check("ovf_err", load_err, 1);
    exp_q = '{{16'h4000, 8'h91}};
    check_writes("ovf", base);
    dl_start(TAP);
    check("ovf_err_cleared", load_err, 0);
    dl_end();

    // Unknown image index: ignored, no stall, no write.
    base = wr_q.size();
    dl_start(8'd7);
    hps_byte(8'd7, 25'd0, 8'hEE);
    check("unk_wait", ioctl_wait, 0);
    dl_end();
    check("unk_no_write", wr_q.size() - base, 0);

    // Randomized TAP with concurrent CPU reads.
    ld = 16'h1000 | 16'($urandom_range(0, 255));
    build_tap(ld, ld + 16'($urandom_range(1, 300)), 16'h0000, 8'd2, $urandom_range(130, 384));
    tap_model();
    base = wr_q.size(); svb = sv_cnt;
    dl_start(TAP);
    fork
      send_file(TAP);
      cpu_burst(40);
    join
    dl_end();
    check_writes("tap_rand", base);
    check("tap_rand_err", load_err, 0);
    repeat (3) begin @(posedge clk_sys); #1; end
`ifdef KC_LOAD_AUTOSTART_EN
    check("auto_none_args2", sv_cnt - svb, 0);
`endif

    // Load address wrap through 0xFFFF with suppression at end_addr.
    build_tap(16'hFFFC, 16'hFFFE, 16'h0000, 8'd0, 6);
    tap_model();
    base = wr_q.size();
    dl_start(TAP);
    send_file(TAP);
    dl_end();
    check("wrap_cnt", wr_q.size() - base, 4);
    check_writes("wrap", base);

    // Reset mid-TAP with the buffer held full by CPU traffic.
    build_tap(16'h2000, 16'h2100, 16'h0000, 8'd0, 5);
    cpu_we = 1'b0; cpu_addr = 16'hF020; cpu_req = 1'b1;
    dl_start(TAP);
    for (int i = 0; i <= 146; i++) hps_byte(TAP, 25'(i), file_q[i]);
    check("rst_mid_full", ioctl_wait, 1);
    reset = 1'b1; ioctl_download = 1'b0; cpu_req = 1'b0;
    base = wr_q.size(); en0 = mem_en_cnt;
    @(negedge clk_sys);
    check("rst_mid_wait", ioctl_wait, 0);
    check("rst_mid_busy", load_busy, 0);
    check("rst_mid_mem_en", mem_en, 0);
    @(posedge clk_sys); #1;
    reset = 1'b0;
    repeat (3) begin @(posedge clk_sys); #1; end
    check("rst_after_wait", ioctl_wait, 0);
    check("rst_after_busy", load_busy, 0);
    check("rst_after_no_mem", mem_en_cnt - en0, 0);
    check("rst_after_no_write", wr_q.size() - base, 0);

    // Fresh download decodes from offset 0.
    ld = 16'h2800 | 16'($urandom_range(0, 255));
    build_tap(ld, ld + 16'($urandom_range(100, 200)), 16'h0000, 8'd0, 150);
    tap_model();
    base = wr_q.size();
    dl_start(TAP);
    send_file(TAP);
    dl_end();
    check_writes("tap_fresh", base);
    check("tap_fresh_err", load_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
